// File: rtl/instr_loader_pkg.sv
// instr_pkg: shared FSM states, word/chunk widths and opcode field positions
package instr_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam int IW = 9;
  localparam int CW = 3;
  localparam int CHUNKS = 3;
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int ARG_MSB = 5;
  localparam int ARG_LSB = 0;
endpackage

// File: rtl/instr_loader_chunk_assembler.sv
// chunk_assembler: shifts 3-bit SDATA chunks (MS first) into a 9-bit word; en=accept chunk, clr=drop partial, done=word complete, word=assembled value
module chunk_assembler
  import instr_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic          en,
  input  logic          clr,
  input  logic [CW-1:0] sdata,
  output logic          done,
  output logic [IW-1:0] word
);
  logic [IW-CW-1:0] sh;
  logic [1:0] cnt;
  assign done = en && cnt == 2'(CHUNKS - 1);
  assign word = {sh, sdata};
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      sh <= '0;
      cnt <= 2'd0;
    end else if (clr) cnt <= 2'd0;
    else if (en) begin
      sh <= word[IW-CW-1:0];
      cnt <= done ? 2'd0 : cnt + 2'd1;
    end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: buffers 9-bit words from the 3-bit SDATA/SVALID bus and replays them as INSTRUCTION/write_en on RUN; CLEAR empties, busy/count/overflow report status
module instr_loader
  import instr_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int GAP = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [CW-1:0]          SDATA,
  input  logic                   SVALID,
  input  logic                   RUN,
  input  logic                   CLEAR,
  output logic [IW-1:0]          INSTRUCTION,
  output logic                   write_en,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  state_t state, state_n;
  logic [AW-1:0] idx, idx_n;
  logic [3:0] gcnt, gcnt_n;
  logic [IW-1:0] mem [DEPTH];
  logic [IW-1:0] word;
  logic idle, start, done, last;
  assign idle = state == IDLE;
  assign start = idle && RUN && !CLEAR && |count;
  assign last = {1'b0, idx} == count - (AW+1)'(1);
  assign busy = !idle || write_en;
  chunk_assembler u_asm (
    .CLK(CLK),
    .RESET(RESET),
    .en(idle && SVALID && !CLEAR && !start),
    .clr(idle && (CLEAR || start)),
    .sdata(SDATA),
    .done(done),
    .word(word)
  );
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      idx <= '0;
      gcnt <= 4'd0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      gcnt <= gcnt_n;
    end
  always_comb begin
    state_n = state;
    idx_n = idx;
    gcnt_n = gcnt;
    case (state)
      IDLE: if (start) begin
        state_n = ISSUE;
        idx_n = '0;
      end
      ISSUE: begin
        idx_n = idx + AW'(1);
        gcnt_n = 4'(GAP - 1);
        state_n = last ? IDLE : GAP > 0 ? WAIT : ISSUE;
      end
      WAIT: begin
        gcnt_n = gcnt - 4'd1;
        state_n = gcnt == 4'd0 ? ISSUE : WAIT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET)
    if (RESET) begin
      INSTRUCTION <= '0;
      write_en <= 1'b0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      write_en <= state == ISSUE;
      if (state == ISSUE) INSTRUCTION <= mem[idx];
      if (idle && CLEAR) begin
        count <= '0;
        overflow <= 1'b0;
      end else if (done) begin
        if (count == FULL) overflow <= 1'b1;
        else count <= count + (AW+1)'(1);
      end
    end
  always_ff @(posedge CLK)
    if (done && count != FULL) mem[count[AW-1:0]] <= word;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: three instances (GAP 0/1/2) on shared stimulus, checked every cycle against a per-instance schedule model
module tb_instr_loader;
  localparam int DEPTH = 8;
  localparam int GAPS [3] = '{0, 1, 2};
  logic CLK, RESET, SVALID, RUN, CLEAR;
  logic [2:0] SDATA;
  logic [8:0] ins [3];
  logic we [3], bsy [3], ovf [3];
  logic [3:0] cnt [3];
  int nvec, nerr, cyc;
  int mcnt [3], mnch [3], mpart [3], ms [3], ml [3], eins [3];
  int mmem [3][DEPTH];
  bit movf [3], ewe [3], ebusy [3];
  instr_loader #(.DEPTH(DEPTH), .GAP(0)) u0 (.CLK(CLK), .RESET(RESET), .SDATA(SDATA), .SVALID(SVALID), .RUN(RUN), .CLEAR(CLEAR),
    .INSTRUCTION(ins[0]), .write_en(we[0]), .busy(bsy[0]), .count(cnt[0]), .overflow(ovf[0]));
  instr_loader #(.DEPTH(DEPTH), .GAP(1)) u1 (.CLK(CLK), .RESET(RESET), .SDATA(SDATA), .SVALID(SVALID), .RUN(RUN), .CLEAR(CLEAR),
    .INSTRUCTION(ins[1]), .write_en(we[1]), .busy(bsy[1]), .count(cnt[1]), .overflow(ovf[1]));
  instr_loader #(.DEPTH(DEPTH), .GAP(2)) u2 (.CLK(CLK), .RESET(RESET), .SDATA(SDATA), .SVALID(SVALID), .RUN(RUN), .CLEAR(CLEAR),
    .INSTRUCTION(ins[2]), .write_en(we[2]), .busy(bsy[2]), .count(cnt[2]), .overflow(ovf[2]));
  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end
  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got %0d exp %0d cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic model_reset;
    for (int g = 0; g < 3; g++) begin
      mcnt[g] = 0; mnch[g] = 0; mpart[g] = 0; movf[g] = 0;
      ms[g] = -100; ml[g] = -100; eins[g] = 0; ewe[g] = 0; ebusy[g] = 0;
    end
  endtask
  task automatic model_edge;
    if (RESET) begin
      model_reset();
      return;
    end
    for (int g = 0; g < 3; g++) begin
      int p, d;
      p = 1 + GAPS[g];
      if (cyc > ml[g]) begin
        if (CLEAR) begin
          mcnt[g] = 0; mnch[g] = 0; movf[g] = 0;
        end else if (RUN && mcnt[g] > 0) begin
          ms[g] = cyc;
          ml[g] = cyc + 1 + (mcnt[g] - 1) * p;
          mnch[g] = 0;
        end else if (SVALID) begin
          mpart[g] = ((mpart[g] << 3) | int'(SDATA)) & 'h1FF;
          mnch[g]++;
          if (mnch[g] == 3) begin
            mnch[g] = 0;
            if (mcnt[g] == DEPTH) movf[g] = 1;
            else mmem[g][mcnt[g]++] = mpart[g];
          end
        end
      end
      ewe[g] = 0;
      if (cyc > ms[g] && cyc <= ml[g]) begin
        d = cyc - ms[g] - 1;
        if (d % p == 0) begin
          ewe[g] = 1;
          eins[g] = mmem[g][d / p];
        end
      end
      ebusy[g] = cyc >= ms[g] && cyc <= ml[g];
    end
  endtask
  task automatic check_all;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("write_en%0d", g), int'(we[g]), int'(ewe[g]));
      chk($sformatf("instr%0d", g), int'(ins[g]), eins[g]);
      chk($sformatf("busy%0d", g), int'(bsy[g]), int'(ebusy[g]));
      chk($sformatf("count%0d", g), int'(cnt[g]), mcnt[g]);
      chk($sformatf("overflow%0d", g), int'(ovf[g]), int'(movf[g]));
    end
  endtask
  task automatic step;
    @(posedge CLK);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask
  task automatic do_reset;
    RESET = 1;
    #1;
    model_reset();
    check_all();
    step();
    RESET = 0;
  endtask
  task automatic send_word(input int w);
    for (int i = 0; i < 3; i++) begin
      SVALID = 1;
      SDATA = 3'((w >> (3 * (2 - i))) & 7);
      step();
    end
    SVALID = 0;
  endtask
  task automatic run_pulse;
    RUN = 1;
    step();
    RUN = 0;
  endtask
  task automatic clear;
    CLEAR = 1;
    step();
    CLEAR = 0;
  endtask
  task automatic wait_idle;
    for (int i = 0; i < 200; i++) begin
      if (!(bsy[0] || bsy[1] || bsy[2])) return;
      step();
    end
    chk("idle_timeout", 1, 0);
  endtask
  initial begin
    nvec = 0; nerr = 0; cyc = 0;
    RESET = 1; SVALID = 0; RUN = 0; CLEAR = 0; SDATA = 0;
    model_reset();
    step();
    RESET = 0;
    step();
    send_word('h1A5);
    run_pulse();
    wait_idle();
    step();
    clear();
    send_word('h001); send_word('h0FF); send_word('h100);
    run_pulse();
    wait_idle();
    step();
    clear();
    for (int i = 0; i < DEPTH + 1; i++) send_word(int'($urandom_range(0, 511)));
    run_pulse();
    wait_idle();
    clear();
    for (int i = 0; i < 4; i++) send_word(int'($urandom_range(0, 511)));
    run_pulse();
    step(); step(); step();
    do_reset();
    run_pulse();
    repeat (6) step();
    send_word('h155);
    SVALID = 1; SDATA = 3'd7; step(); SDATA = 3'd2; step(); SVALID = 0;
    run_pulse();
    wait_idle();
    send_word('h0AA);
    run_pulse();
    wait_idle();
    RUN = 1;
    step();
    RUN = 0;
    for (int i = 0; i < 2; i++) begin
      SVALID = 1'($urandom);
      SDATA = 3'($urandom);
      step();
    end
    SVALID = 0;
    wait_idle();
    run_pulse();
    wait_idle();
    clear();
    for (int i = 0; i < 4; i++) send_word(int'($urandom_range(0, 511)));
    RUN = 1;
    repeat (30) step();
    RUN = 0;
    wait_idle();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      SVALID = $urandom_range(0, 1) == 1;
      SDATA = 3'($urandom);
      RUN = $urandom_range(0, 19) == 0;
      CLEAR = $urandom_range(0, 59) == 0;
      step();
    end
    SVALID = 0; RUN = 0; CLEAR = 0;
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
